fb_write_queue: RTL and testbench
=================================

// Module: fb_write_queue
// PURPOSE
//  Downstream of the line-drawing datapath: buffers fragments (FB address + 1-bit R/G/B)
//  in a small FIFO and drains them to the framebuffer memory write port under a
//  ready handshake. Signals line completion only once every fragment of the line is
//  written. Also performs a full-screen clear to a background colour.
// PARAMETERS
//  ADDR_W   17     framebuffer address width (matches generator FB_addr)
//  DEPTH    8      FIFO entries (power of 2, >=2)
//  FB_SIZE  76800  valid pixel count (320x240); addresses >= FB_SIZE never written
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous reset, active-high
//  frag_valid  in   1       fragment present this cycle
//  frag_addr   in   ADDR_W  fragment FB address
//  frag_rgb    in   3       {red,green,blue} of fragment
//  frag_finish in   1       generator finish; level or pulse, rising edge counts
//  frag_stall  out  1       1 = fragment this cycle is not accepted
//  clear_req   in   1       request full-screen clear (level, held until clear_ack)
//  clear_rgb   in   3       background colour, sampled at clear_ack
//  clear_ack   out  1       1-cycle pulse: clear accepted
//  busy        out  1       state != IDLE or FIFO non-empty or finish pending
//  line_done   out  1       1-cycle pulse: all fragments before finish written
//  overflow    out  1       sticky: a fragment was dropped (cleared only by rst)
//  fb_we       out  1       write request to framebuffer memory
//  fb_addr     out  ADDR_W  write address
//  fb_data     out  3       write data
//  fb_ready    in   1       memory accepts write on edge where fb_we&&fb_ready
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, FIFO empty, pending_finish=0, finish edge reg=0,
//   all outputs 0 (frag_stall=0, fb_we=0, fb_addr=0, fb_data=0, overflow=0).
//  FSM: IDLE, DRAIN, CLEAR.
//   IDLE  -> DRAIN when FIFO non-empty; -> CLEAR when clear_req && FIFO empty &&
//            !pending_finish (drain has priority over clear).
//   DRAIN -> IDLE when FIFO empty and no write outstanding.
//   CLEAR -> IDLE after write of address FB_SIZE-1 accepted.
//  Push: frag_valid && !frag_stall -> entry {addr,rgb} written at tail.
//   frag_stall = FIFO full || state==CLEAR (combinational).
//   frag_valid && frag_stall -> fragment dropped, overflow<=1.
//   Push and pop same cycle when full: pop frees slot but stall still 1 that cycle.
//  Pop/write: head entry drives fb_addr/fb_data with fb_we=1 (registered outputs,
//   1 cycle after entry reaches head); held stable until fb_ready=1 on an edge; then pop.
//   Head with addr >= FB_SIZE: popped in 1 cycle, fb_we stays 0, not counted as error.
//   Throughput: 1 write/cycle while fb_ready=1 and FIFO non-empty (back-to-back).
//  Finish: rising edge of frag_finish sets pending_finish. Fragment pushed in same
//   cycle belongs to that line. line_done pulses the cycle after pending_finish=1,
//   FIFO empty and no write outstanding; pending_finish clears with the pulse.
//   Second finish edge while pending: ignored (merged, single line_done).
//  Clear: clear_ack pulses on IDLE->CLEAR; colour latched. Counter 0..FB_SIZE-1,
//   fb_we=1 each address, advance only on fb_ready. No fragments accepted in CLEAR.
//   clear_req while draining: waits; no ack until drain done and line_done issued.
//  rst mid-DRAIN/CLEAR: aborts immediately, FIFO contents discarded, no line_done.
// TESTING
//  1 fb_ready=1, 3 frags (addr 10,11,12 rgb 3'b100) then finish -> fb_we 3 consecutive
//    cycles, addrs 10,11,12, line_done pulses once after third write.
//  2 fb_ready=0 for 20 cycles, push 10 frags (DEPTH=8) -> stall after 8, overflow=1,
//    only first 8 written in order once fb_ready=1.
//  3 fb_ready toggles 1/0 each cycle -> fb_addr/fb_data stable while fb_we&&!fb_ready,
//    no write duplicated or lost.
//  4 clear_req with FB_SIZE=16, clear_rgb=3'b010 -> clear_ack 1 cycle, 16 writes addr 0..15
//    data 010, busy falls after addr 15; frag_valid during clear -> overflow=1.
//  5 frag addr 76800 then addr 5, finish -> only addr 5 written, line_done once;
//    clear_req raised mid-drain -> ack only after line_done.
//  6 assert rst mid-drain with 4 entries queued -> next cycle fb_we=0, busy=0, no line_done.

Source files
------------

// File: rtl/fb_write_queue.sv
// fb_write_queue: fragment FIFO draining to the framebuffer write port, with line-done tracking and full-screen clear
module fb_write_queue #(
  parameter int ADDR_W  = 17,
  parameter int DEPTH   = 8,
  parameter int FB_SIZE = 76800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frag_valid,
  input  logic [ADDR_W-1:0] frag_addr,
  input  logic [2:0]        frag_rgb,
  input  logic              frag_finish,
  output logic              frag_stall,
  input  logic              clear_req,
  input  logic [2:0]        clear_rgb,
  output logic              clear_ack,
  output logic              busy,
  output logic              line_done,
  output logic              overflow,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  input  logic              fb_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(FB_SIZE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_SIZE - 1);
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
  state_t state, state_n;
  logic [ADDR_W+2:0] mem [DEPTH];
  logic [ADDR_W+2:0] head, nh;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, cnt_a, cnt_n;
  logic fin_q, pending, push, pop, head_bad, nh_bad, fin_rise, done, go_clear, clr_last, we_n;
  assign head       = mem[rd_ptr];
  assign head_bad   = {1'b0, head[ADDR_W+2:3]} >= LIM;
  assign frag_stall = count == (AW+1)'(DEPTH) || state == CLEAR;
  assign push       = frag_valid && !frag_stall;
  assign pop        = count != 0 && (head_bad || fb_ready);
  assign cnt_a      = count - (AW+1)'(pop);
  assign cnt_n      = cnt_a + (AW+1)'(push);
  // next head: the incoming fragment bypasses the array when the queue drains empty this cycle
  assign nh         = cnt_a == 0 ? {frag_addr, frag_rgb} : mem[pop ? rd_ptr + AW'(1) : rd_ptr];
  assign nh_bad     = {1'b0, nh[ADDR_W+2:3]} >= LIM;
  assign we_n       = cnt_n != 0 && !nh_bad;
  assign fin_rise   = frag_finish && !fin_q;
  assign done       = pending && count == 0 && state != CLEAR;
  assign go_clear   = state == IDLE && clear_req && count == 0 && !push && !pending && !fin_rise;
  assign clr_last   = state == CLEAR && fb_ready && fb_addr == LAST;
  assign busy       = state != IDLE || count != 0 || pending;
  always_comb begin
    state_n = state == CLEAR ? (clr_last ? IDLE : CLEAR) :
              cnt_n != 0     ? DRAIN :
              go_clear       ? CLEAR : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fin_q     <= 1'b0;
      pending   <= 1'b0;
      clear_ack <= 1'b0;
      line_done <= 1'b0;
      overflow  <= 1'b0;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
    end else begin
      state     <= state_n;
      fin_q     <= frag_finish;
      if (push) begin
        mem[wr_ptr] <= {frag_addr, frag_rgb};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr    <= rd_ptr + AW'(pop);
      count     <= cnt_n;
      overflow  <= overflow | (frag_valid && frag_stall);
      pending   <= pending ? !done : fin_rise;
      line_done <= done;
      clear_ack <= go_clear;
      if (go_clear) begin
        fb_we   <= 1'b1;
        fb_addr <= '0;
        fb_data <= clear_rgb;
      end else if (state == CLEAR) begin
        if (fb_ready) begin
          fb_we   <= !clr_last;
          fb_addr <= clr_last ? '0 : fb_addr + ADDR_W'(1);
        end
      end else begin
        fb_we <= we_n;
        if (we_n) begin
          fb_addr <= nh[ADDR_W+2:3];
          fb_data <= nh[2:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_fb_write_queue.sv
// tb_fb_write_queue: directed scenarios plus random traffic, checked every cycle against a queue-based model
module tb_fb_write_queue;
  localparam int ADDR_W = 17, DEPTH = 8, FB_SIZE = 16;
  logic clk, rst, frag_valid, frag_finish, frag_stall, clear_req, clear_ack, busy, line_done, overflow, fb_we, fb_ready;
  logic [ADDR_W-1:0] frag_addr, fb_addr;
  logic [2:0] frag_rgb, clear_rgb, fb_data;
  int tests = 0, fails = 0, cyc = 0, ld_cnt = 0, ack_cnt = 0, ld_cyc = 0, ack_cyc = 0;
  logic [19:0] wlog [$];
  int wcyc [$];

  fb_write_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FB_SIZE(FB_SIZE)) dut (
    .clk(clk), .rst(rst), .frag_valid(frag_valid), .frag_addr(frag_addr), .frag_rgb(frag_rgb),
    .frag_finish(frag_finish), .frag_stall(frag_stall), .clear_req(clear_req), .clear_rgb(clear_rgb),
    .clear_ack(clear_ack), .busy(busy), .line_done(line_done), .overflow(overflow), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // behavioural model: queue of pending fragments, clear sweep index, finish bookkeeping
  typedef struct packed {logic [ADDR_W-1:0] a; logic [2:0] c;} ent_t;
  ent_t q [$];
  bit armed = 0, m_clr, m_pend, m_fin, m_ack, m_ld, m_ovf, m_we;
  int m_idx;
  logic [2:0] m_col, m_data;
  logic [ADDR_W-1:0] m_addr;
  always @(posedge clk) begin
    bit stall, push, done, go, rise, pend0, clr0;
    int sz0;
    armed = 1;
    if (rst) begin
      q.delete();
      {m_clr, m_pend, m_fin, m_ack, m_ld, m_ovf, m_we} = '0;
      m_idx = 0; m_addr = '0; m_data = '0; m_col = '0;
    end else begin
      sz0 = q.size(); clr0 = m_clr; pend0 = m_pend;
      stall = sz0 == DEPTH || clr0;
      push = frag_valid && !stall;
      rise = frag_finish && !m_fin;
      m_fin = frag_finish;
      if (frag_valid && stall) m_ovf = 1;
      done = pend0 && sz0 == 0 && !clr0;
      m_ld = done;
      m_pend = pend0 ? !done : rise;
      go = !clr0 && sz0 == 0 && clear_req && !push && !pend0 && !rise;
      m_ack = go;
      if (clr0) begin
        if (fb_ready) begin
          if (m_idx == FB_SIZE - 1) m_clr = 0;
          else m_idx++;
        end
      end else if (sz0 != 0 && (int'(q[0].a) >= FB_SIZE || fb_ready)) void'(q.pop_front());
      if (push) q.push_back('{frag_addr, frag_rgb});
      if (go) begin m_clr = 1; m_idx = 0; m_col = clear_rgb; end
      if (m_clr) begin
        m_we = 1; m_addr = ADDR_W'(m_idx); m_data = m_col;
      end else begin
        m_we = q.size() != 0 && int'(q[0].a) < FB_SIZE;
        if (m_we) begin m_addr = q[0].a; m_data = q[0].c; end
      end
    end
  end

  always @(negedge clk) if (armed) begin
    chk("fb_we", fb_we, m_we);
    if (m_we) begin
      chk("fb_addr", fb_addr, m_addr);
      chk("fb_data", fb_data, m_data);
    end
    chk("frag_stall", frag_stall, q.size() == DEPTH || m_clr);
    chk("busy", busy, m_clr || q.size() != 0 || m_pend);
    chk("line_done", line_done, m_ld);
    chk("clear_ack", clear_ack, m_ack);
    chk("overflow", overflow, m_ovf);
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (fb_we && fb_ready) begin wlog.push_back({fb_addr, fb_data}); wcyc.push_back(cyc); end
      if (line_done) begin ld_cnt++; ld_cyc = cyc; end
      if (clear_ack) begin ack_cnt++; ack_cyc = cyc; end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    rst = 1; frag_valid = 0; frag_finish = 0; clear_req = 0;
    tick(2);
    rst = 0;
    wlog.delete(); wcyc.delete(); ld_cnt = 0; ack_cnt = 0;
  endtask

  task automatic push(logic [ADDR_W-1:0] a, logic [2:0] c);
    frag_valid = 1; frag_addr = a; frag_rgb = c;
    tick();
    frag_valid = 0;
  endtask

  task automatic wait_idle(string n, int max);
    int k = 0;
    while (busy && k < max) begin tick(); k++; end
    chk(n, busy, 0);
  endtask

  initial begin
    int k;
    rst = 1; frag_valid = 0; frag_addr = '0; frag_rgb = '0; frag_finish = 0;
    clear_req = 0; clear_rgb = '0; fb_ready = 0;
    do_reset();
    chk("rst_fb_we", fb_we, 0);
    chk("rst_stall", frag_stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_overflow", overflow, 0);

    // back-to-back drain of one short line
    fb_ready = 1;
    for (int i = 10; i < 13; i++) push(ADDR_W'(i), 3'b100);
    frag_finish = 1; tick(); frag_finish = 0;
    k = 0;
    while (ld_cnt == 0 && k < 50) begin tick(); k++; end
    tick(5);
    chk("t1_ld_cnt", ld_cnt, 1);
    chk("t1_writes", wlog.size(), 3);
    if (wlog.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t1_entry", wlog[i], {17'(10 + i), 3'b100});
      chk("t1_consecutive", wcyc[2] - wcyc[0], 2);
    end

    // overflow while memory is not ready
    do_reset();
    fb_ready = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) chk("t2_stall_full", frag_stall, 1);
      push(ADDR_W'(i), 3'(i));
    end
    tick(10);
    chk("t2_overflow", overflow, 1);
    fb_ready = 1;
    wait_idle("t2_idle", 40);
    chk("t2_writes", wlog.size(), 8);
    for (int i = 0; i < wlog.size() && i < 8; i++) chk("t2_entry", wlog[i], {17'(i), 3'(i)});

    // alternating ready
    do_reset();
    for (int i = 0; i < 40; i++) begin
      frag_valid = i < 6; frag_addr = ADDR_W'(2 + i); frag_rgb = 3'(i + 1);
      fb_ready = i[0];
      tick();
    end
    frag_valid = 0; fb_ready = 1;
    wait_idle("t3_idle", 20);
    chk("t3_writes", wlog.size(), 6);
    for (int i = 0; i < wlog.size() && i < 6; i++) chk("t3_entry", wlog[i], {17'(2 + i), 3'(i + 1)});

    // full-screen clear with a fragment attempted mid-clear
    do_reset();
    clear_rgb = 3'b010; clear_req = 1;
    k = 0;
    while (ack_cnt == 0 && k < 10) begin tick(); k++; end
    clear_req = 0; clear_rgb = 3'b111;
    push(ADDR_W'(3), 3'b001);
    wait_idle("t4_idle", 40);
    chk("t4_ack_cnt", ack_cnt, 1);
    chk("t4_overflow", overflow, 1);
    chk("t4_writes", wlog.size(), 16);
    for (int i = 0; i < wlog.size() && i < 16; i++) chk("t4_entry", wlog[i], {17'(i), 3'b010});

    // out-of-range fragment skipped; clear waits for line_done
    do_reset();
    push(ADDR_W'(76800), 3'b001);
    frag_finish = 1; clear_req = 1; clear_rgb = 3'b001;
    push(ADDR_W'(5), 3'b110);
    k = 0;
    while (ack_cnt == 0 && k < 30) begin tick(); k++; end
    clear_req = 0;
    wait_idle("t5_idle", 40);
    frag_finish = 0;
    chk("t5_ld_cnt", ld_cnt, 1);
    chk("t5_ack_cnt", ack_cnt, 1);
    chk("t5_order", ld_cyc < ack_cyc, 1);
    chk("t5_writes", wlog.size(), 17);
    if (wlog.size() == 17) begin
      chk("t5_first", wlog[0], {17'd5, 3'b110});
      chk("t5_last", wlog[16], {17'd15, 3'b001});
    end

    // reset aborts a drain with pending finish
    do_reset();
    fb_ready = 0;
    frag_finish = 1;
    for (int i = 0; i < 4; i++) push(ADDR_W'(i), 3'b011);
    tick(2);
    rst = 1; frag_finish = 0;
    tick();
    chk("t6_fb_we", fb_we, 0);
    chk("t6_busy", busy, 0);
    rst = 0; fb_ready = 1;
    tick(10);
    chk("t6_no_ld", ld_cnt, 0);
    chk("t6_no_write", wlog.size(), 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      frag_valid = $urandom_range(0, 2) != 0;
      frag_addr = ADDR_W'($urandom_range(0, 23));
      frag_rgb = 3'($urandom);
      fb_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 29) == 0) frag_finish = ~frag_finish;
      if (clear_req && clear_ack) clear_req = 0;
      else if (!clear_req && $urandom_range(0, 199) == 0) begin clear_req = 1; clear_rgb = 3'($urandom); end
      tick();
    end
    frag_valid = 0; frag_finish = 0; clear_req = 0; fb_ready = 1;
    wait_idle("rand_idle", 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
